// File: rtl/clk_duty_monitor.sv
// Measures high time, low time and period of an asynchronous clock-like input
// in reference-clock cycles and emits one checked record per full period.
module clk_duty_monitor #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int EXP_HIGH    = 3,
  parameter int EXP_LOW     = 7,
  parameter int TOL         = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             meas_en,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period_cnt,
  output logic             in_spec,
  output logic             overrun,
  output logic             stuck
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] EXP_H   = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0] EXP_L   = CNT_W'(EXP_LOW);
  localparam logic [CNT_W-1:0] TOL_V   = CNT_W'(TOL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  function automatic logic within_tol(input logic [CNT_W-1:0] meas,
                                      input logic [CNT_W-1:0] expected);
    return abs_diff(meas, expected) <= TOL_V;
  endfunction

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   fall;

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_W-1:0]       hcnt;
  logic [CNT_W-1:0]       lcnt;
  logic                   publish;
  logic                   in_spec_nxt;
  logic [CNT_W:0]         period_nxt;

  // Input synchronizer and edge detect
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0 <= '0;
      s_d     <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], sig_in};
      s_d     <= s;
    end
  end

  assign s    = sync_p0[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Disabling measurement overrides every transition
  always_comb begin
    state_nxt = state;
    if (!meas_en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = ARM;
        ARM:     if (rise) state_nxt = HIGH;
        HIGH:    if (fall) state_nxt = LOW;
        LOW:     if (rise) state_nxt = HIGH;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    publish = 1'b0;
    stuck   = 1'b0;
    case (state)
      HIGH: stuck = (hcnt == CNT_MAX);
      LOW: begin
        stuck   = (lcnt == CNT_MAX);
        publish = meas_en & rise;
      end
      default: begin
        publish = 1'b0;
        stuck   = 1'b0;
      end
    endcase
  end

  // Phase counters
  always_ff @(posedge clock) begin
    if (reset || !meas_en) begin
      hcnt <= '0;
      lcnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          hcnt <= '0;
          lcnt <= '0;
        end
        ARM: begin
          if (rise) hcnt <= CNT_W'(1);
        end
        HIGH: begin
          if (fall) begin
            lcnt <= CNT_W'(1);
          end else if (s) begin
            hcnt <= sat_inc(hcnt);
          end
        end
        LOW: begin
          if (rise) begin
            hcnt <= CNT_W'(1);
            lcnt <= '0;
          end else if (!s) begin
            lcnt <= sat_inc(lcnt);
          end
        end
        default: begin
          hcnt <= '0;
          lcnt <= '0;
        end
      endcase
    end
  end

  assign in_spec_nxt = within_tol(hcnt, EXP_H) & within_tol(lcnt, EXP_L);
  assign period_nxt  = {1'b0, hcnt} + {1'b0, lcnt};

  // Result register: a held record is never overwritten, a colliding one is dropped
  always_ff @(posedge clock) begin
    if (reset) begin
      res_valid  <= 1'b0;
      high_cnt   <= '0;
      low_cnt    <= '0;
      period_cnt <= '0;
      in_spec    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (publish && (!res_valid || res_ready)) begin
        res_valid  <= 1'b1;
        high_cnt   <= hcnt;
        low_cnt    <= lcnt;
        period_cnt <= period_nxt;
        in_spec    <= in_spec_nxt;
      end else begin
        if (publish) overrun <= 1'b1;
        if (res_valid && res_ready) res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_duty_monitor.sv
// Bench for clk_duty_monitor: vector table, directed corner sequences and a
// randomized waveform run against a period-level reference model.
module tb_clk_duty_monitor;

  localparam int EXP_H = 3;
  localparam int EXP_L = 7;
  localparam int TOLR  = 1;
  localparam int NV    = 8;
  localparam int RN    = 800;

  logic        clock = 1'b0;
  logic        reset;
  logic        sig_in;
  logic        meas_en;
  logic        res_ready;

  logic        res_valid;
  logic [15:0] high_cnt;
  logic [15:0] low_cnt;
  logic [16:0] period_cnt;
  logic        in_spec;
  logic        overrun;
  logic        stuck;

  logic        res_valid8;
  logic [7:0]  high_cnt8;
  logic [7:0]  low_cnt8;
  logic [8:0]  period_cnt8;
  logic        in_spec8;
  logic        overrun8;
  logic        stuck8;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int h;
    int l;
    int p;
    int s;
  } rec_t;

  typedef struct {
    int h_in;
    int l_in;
    int exp_h;
    int exp_l;
    int exp_p;
    int exp_s;
  } vec_t;

  rec_t cap_q[$];
  vec_t vecs[NV];

  logic wave[RN];
  logic rdyv[RN];
  logic pubv[RN];
  rec_t recv[RN];

  always #5 clock = ~clock;

  clk_duty_monitor dut (
    .clock(clock), .reset(reset), .sig_in(sig_in), .meas_en(meas_en),
    .res_valid(res_valid), .res_ready(res_ready), .high_cnt(high_cnt),
    .low_cnt(low_cnt), .period_cnt(period_cnt), .in_spec(in_spec),
    .overrun(overrun), .stuck(stuck)
  );

  clk_duty_monitor #(.CNT_W(8)) dut8 (
    .clock(clock), .reset(reset), .sig_in(sig_in), .meas_en(meas_en),
    .res_valid(res_valid8), .res_ready(res_ready), .high_cnt(high_cnt8),
    .low_cnt(low_cnt8), .period_cnt(period_cnt8), .in_spec(in_spec8),
    .overrun(overrun8), .stuck(stuck8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int abs_i(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int ref_in_spec(input int h, input int l);
    return ((abs_i(h - EXP_H) <= TOLR) && (abs_i(l - EXP_L) <= TOLR)) ? 1 : 0;
  endfunction

  task automatic tick(input logic sig, input logic en, input logic rdy);
    sig_in    = sig;
    meas_en   = en;
    res_ready = rdy;
    if (res_valid && rdy)
      cap_q.push_back('{int'(high_cnt), int'(low_cnt), int'(period_cnt), int'(in_spec)});
    @(posedge clock);
    #1;
  endtask

  task automatic period(input int h, input int l, input logic rdy);
    repeat (h) tick(1'b1, 1'b1, rdy);
    repeat (l) tick(1'b0, 1'b1, rdy);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    sig_in    = 1'b0;
    meas_en   = 1'b0;
    res_ready = 1'b0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_rec(input string name, input int h, input int l, input int p, input int s);
    check({name, " high_cnt"}, high_cnt, h);
    check({name, " low_cnt"}, low_cnt, l);
    check({name, " period_cnt"}, period_cnt, p);
    check({name, " in_spec"}, in_spec, s);
  endtask

  task automatic random_test();
    int idx;
    int h;
    int l;
    int prev_r;
    logic mv;
    logic movr;
    rec_t mrec;
    for (int i = 0; i < RN; i++) begin
      wave[i] = 1'b0;
      pubv[i] = 1'b0;
      rdyv[i] = ($urandom_range(3) != 0);
      recv[i] = '{0, 0, 0, 0};
    end
    idx = 2 + $urandom_range(3);
    while (idx < RN) begin
      h = 1 + $urandom_range(9);
      l = 1 + $urandom_range(9);
      for (int k = 0; k < h && idx < RN; k++) begin
        wave[idx] = 1'b1;
        idx++;
      end
      idx += l;
    end
    // A record covers rise-to-rise; it is registered three cycles after the closing rise is driven
    prev_r = -1;
    for (int r = 1; r < RN; r++) begin
      if (wave[r] && !wave[r-1]) begin
        if (prev_r >= 0 && r + 2 < RN) begin
          int hi;
          hi = 0;
          for (int k = prev_r; k < r; k++) if (wave[k]) hi++;
          pubv[r+2] = 1'b1;
          recv[r+2] = '{hi, r - prev_r - hi, r - prev_r, ref_in_spec(hi, r - prev_r - hi)};
        end
        prev_r = r;
      end
    end

    do_reset();
    mv   = 1'b0;
    movr = 1'b0;
    mrec = '{0, 0, 0, 0};
    for (int t = 0; t < RN; t++) begin
      sig_in    = wave[t];
      meas_en   = 1'b1;
      res_ready = rdyv[t];
      check("rnd res_valid", res_valid, mv);
      check("rnd overrun", overrun, movr);
      check("rnd stuck", stuck, 0);
      if (mv) begin
        check("rnd high_cnt", high_cnt, mrec.h);
        check("rnd low_cnt", low_cnt, mrec.l);
        check("rnd period_cnt", period_cnt, mrec.p);
        check("rnd in_spec", in_spec, mrec.s);
      end
      if (pubv[t]) begin
        if (!mv || rdyv[t]) begin
          mrec = recv[t];
          mv   = 1'b1;
        end else begin
          movr = 1'b1;
        end
      end else if (mv && rdyv[t]) begin
        mv = 1'b0;
      end
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    vecs[0] = '{3, 7, 3, 7, 10, 1};
    vecs[1] = '{5, 5, 5, 5, 10, 0};
    vecs[2] = '{4, 6, 4, 6, 10, 1};
    vecs[3] = '{2, 8, 2, 8, 10, 1};
    vecs[4] = '{4, 8, 4, 8, 12, 1};
    vecs[5] = '{2, 6, 2, 6, 8, 1};
    vecs[6] = '{1, 9, 1, 9, 10, 0};
    vecs[7] = '{3, 9, 3, 9, 12, 0};

    do_reset();
    check("reset res_valid", res_valid, 0);
    check("reset high_cnt", high_cnt, 0);
    check("reset low_cnt", low_cnt, 0);
    check("reset period_cnt", period_cnt, 0);
    check("reset in_spec", in_spec, 0);
    check("reset overrun", overrun, 0);
    check("reset stuck", stuck, 0);

    for (int i = 0; i < NV; i++) begin
      do_reset();
      cap_q.delete();
      repeat (4) tick(1'b0, 1'b1, 1'b1);
      period(vecs[i].h_in, vecs[i].l_in, 1'b1);
      check("tbl no record before second rise", cap_q.size(), 0);
      period(vecs[i].h_in, vecs[i].l_in, 1'b1);
      period(vecs[i].h_in, vecs[i].l_in, 1'b1);
      check("tbl record count", cap_q.size(), 2);
      check("tbl overrun", overrun, 0);
      for (int k = 0; k < cap_q.size(); k++) begin
        check("tbl high_cnt", cap_q[k].h, vecs[i].exp_h);
        check("tbl low_cnt", cap_q[k].l, vecs[i].exp_l);
        check("tbl period_cnt", cap_q[k].p, vecs[i].exp_p);
        check("tbl in_spec", cap_q[k].s, vecs[i].exp_s);
      end
    end

    // Back-pressure: first record held, two later ones dropped
    do_reset();
    repeat (4) tick(1'b0, 1'b1, 1'b0);
    period(3, 7, 1'b0);
    period(4, 6, 1'b0);
    check("hs first valid", res_valid, 1);
    check_rec("hs first", 3, 7, 10, 1);
    check("hs no overrun yet", overrun, 0);
    period(4, 6, 1'b0);
    check("hs overrun set", overrun, 1);
    check_rec("hs held", 3, 7, 10, 1);
    repeat (2) tick(1'b1, 1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b1, 1'b0);
    check_rec("hs still held", 3, 7, 10, 1);
    tick(1'b0, 1'b1, 1'b1);
    check("hs valid drops after transfer", res_valid, 0);
    repeat (4) tick(1'b0, 1'b1, 1'b0);
    repeat (3) tick(1'b1, 1'b1, 1'b0);
    check("hs fresh valid", res_valid, 1);
    check_rec("hs fresh", 2, 8, 10, 1);
    check("hs overrun sticky", overrun, 1);

    // Disable mid-HIGH, re-enable while high
    do_reset();
    repeat (4) tick(1'b0, 1'b1, 1'b0);
    period(3, 7, 1'b0);
    repeat (3) tick(1'b1, 1'b1, 1'b0);
    check("dis record before disable", res_valid, 1);
    repeat (2) tick(1'b1, 1'b0, 1'b0);
    check("dis held record valid", res_valid, 1);
    check_rec("dis held", 3, 7, 10, 1);
    repeat (3) tick(1'b1, 1'b1, 1'b0);
    repeat (7) tick(1'b0, 1'b1, 1'b0);
    repeat (3) tick(1'b1, 1'b1, 1'b0);
    check("dis no publish on arming rise", overrun, 0);
    repeat (3) tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    check("dis drained", res_valid, 0);
    repeat (3) tick(1'b0, 1'b1, 1'b0);
    repeat (3) tick(1'b1, 1'b1, 1'b0);
    check("dis first record after rearm", res_valid, 1);
    check_rec("dis rearm", 3, 7, 10, 1);
    check("dis overrun", overrun, 0);

    // Reset mid-LOW with a held record and overrun set
    do_reset();
    repeat (4) tick(1'b0, 1'b1, 1'b0);
    period(3, 7, 1'b0);
    period(4, 6, 1'b0);
    repeat (4) tick(1'b1, 1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b1, 1'b0);
    check("rst pre valid", res_valid, 1);
    check("rst pre overrun", overrun, 1);
    reset = 1'b1;
    tick(1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    check("rst res_valid", res_valid, 0);
    check("rst high_cnt", high_cnt, 0);
    check("rst low_cnt", low_cnt, 0);
    check("rst period_cnt", period_cnt, 0);
    check("rst in_spec", in_spec, 0);
    check("rst overrun", overrun, 0);
    check("rst stuck", stuck, 0);

    // Saturation on the 8-bit instance
    do_reset();
    repeat (2) tick(1'b0, 1'b1, 1'b1);
    sc = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1'b1, 1'b1, 1'b1);
      if (stuck8) sc++;
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b1);
      if (stuck8) sc++;
    end
    check("sat stuck cycles", sc, 46);
    check("sat stuck cleared after fall", stuck8, 0);
    repeat (3) tick(1'b1, 1'b1, 1'b1);
    check("sat res_valid", res_valid8, 1);
    check("sat high_cnt", high_cnt8, 255);
    check("sat low_cnt", low_cnt8, 3);
    check("sat period_cnt", period_cnt8, 258);
    check("sat in_spec", in_spec8, 0);
    check("sat overrun", overrun8, 0);

    random_test();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
